sdram_wr_feeder: RTL and testbench

- Write-side input stage placed directly upstream of the SDRAM frame controller.
- Accepts one 16-bit pixel per cycle from the video input path and buffers it in an internal FIFO.
- Once a full burst is buffered and the controller is ready, issues a one-cycle write request.
- Streams exactly BURST words into the controller's data input while the controller holds rd_ena high.
- Clears its contents on input vsync, aligned with the controller's write-address reset.

---
 rtl/sdram_wr_feeder.sv | 171 +++++++++++++++++
 tb/tb_sdram_wr_feeder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wr_feeder.sv
// rtl/sdram_wr_feeder.sv - pixel FIFO and burst write feeder for the SDRAM frame controller
// Buffers incoming pixels and streams BURST-word write bursts into the controller on request.
module sdram_wr_feeder #(
    parameter int DATA_W = 16,
    parameter int BURST  = 256,
    parameter int DEPTH  = 512,
    parameter int AW     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_i_vsync,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              sd_ready,
    input  logic              rd_ena,
    input  logic              rd_pend,
    output logic              wr,
    output logic [DATA_W-1:0] data,
    output logic [AW:0]       level,
    output logic              busy,
    output logic              ovf,
    output logic              burst_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_XFER
    } state_t;

    localparam logic [AW:0] BURST_L = (AW+1)'(BURST);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] POP_MAX = '1;

    state_t            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       level_q, level_d;
    logic [AW:0]       popped_q, popped_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              flush_q, flush_d;

    logic              clear;
    logic              pop_req;
    logic              push;
    logic              pop;
    logic              full;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d  = state_q;
        popped_d = popped_q;
        flush_d  = flush_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        clear    = 1'b0;
        pop_req  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A pending flush runs here, before any new burst can be requested.
                if (flush_q) begin
                    clear = 1'b1;
                end else if (level_q >= BURST_L && sd_ready && !rd_pend && !p_i_vsync) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rd_ena) begin
                    state_d  = S_XFER;
                    pop_req  = 1'b1;
                    popped_d = {{AW{1'b0}}, 1'b1};
                end
            end
            S_XFER: begin
                if (rd_ena) begin
                    pop_req = (popped_q < BURST_L);
                    if (popped_q != POP_MAX) begin
                        popped_d = popped_q + {{AW{1'b0}}, 1'b1};
                    end
                end else begin
                    state_d  = S_IDLE;
                    popped_d = '0;
                    if (popped_q != BURST_L) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (p_i_vsync) begin
            if (state_q == S_IDLE || state_q == S_REQ) begin
                clear = 1'b1;
            end else begin
                flush_d = 1'b1;
            end
        end

        full = (level_q == DEPTH_L);
        push = pix_valid && !full && !clear;
        // A vsync during REQ can empty the FIFO under a granted burst; never pop an empty FIFO.
        pop  = pop_req && (level_q != '0) && !clear;

        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            flush_d = 1'b0;
        end else begin
            wptr_d  = wptr_q + {{(AW-1){1'b0}}, push};
            rptr_d  = rptr_q + {{(AW-1){1'b0}}, pop};
            level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (pix_valid && full) begin
                ovf_d = 1'b1;
            end
        end

        wr_d   = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            popped_q <= '0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            popped_q <= popped_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            flush_q  <= flush_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= pix_data;
        end
    end

    assign data      = mem[rptr_q];
    assign wr        = wr_q;
    assign busy      = busy_q;
    assign level     = level_q;
    assign ovf       = ovf_q;
    assign burst_err = err_q;

endmodule

// File: tb/tb_sdram_wr_feeder.sv
// tb/tb_sdram_wr_feeder.sv - self-checking bench for sdram_wr_feeder
// A queue-based reference model is compared against the outputs every cycle.
module tb_sdram_wr_feeder;

    localparam int DATA_W = 16;
    localparam int BURST  = 256;
    localparam int DEPTH  = 512;
    localparam int AW     = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              p_i_vsync = 1'b0;
    logic              pix_valid = 1'b0;
    logic [DATA_W-1:0] pix_data = '0;
    logic              sd_ready = 1'b0;
    logic              rd_ena = 1'b0;
    logic              rd_pend = 1'b0;
    logic              wr;
    logic [DATA_W-1:0] data;
    logic [AW:0]       level;
    logic              busy;
    logic              ovf;
    logic              burst_err;

    always #5 clk = ~clk;

    sdram_wr_feeder #(
        .DATA_W(DATA_W),
        .BURST (BURST),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .p_i_vsync(p_i_vsync),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .sd_ready (sd_ready),
        .rd_ena   (rd_ena),
        .rd_pend  (rd_pend),
        .wr       (wr),
        .data     (data),
        .level    (level),
        .busy     (busy),
        .ovf      (ovf),
        .burst_err(burst_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue, burst progress as a phase plus pop count.
    typedef enum {P_IDLE, P_REQ, P_WAIT, P_XFER} phase_t;
    phase_t            m_ph = P_IDLE;
    logic [DATA_W-1:0] m_q[$];
    int                m_cnt = 0;
    bit                m_flush = 0;
    bit                m_ovf = 0;
    bit                m_err = 0;
    bit                m_on = 0;

    task automatic model_step();
        int     sz;
        bit     clr;
        bit     pop;
        phase_t nx;
        if (rst) begin
            m_ph = P_IDLE;
            m_q.delete();
            m_cnt = 0;
            m_flush = 0;
            m_ovf = 0;
            m_err = 0;
            m_on = 1;
            return;
        end
        sz  = m_q.size();
        clr = 0;
        pop = 0;
        nx  = m_ph;
        case (m_ph)
            P_IDLE: begin
                if (m_flush) clr = 1;
                else if (sz >= BURST && sd_ready && !rd_pend && !p_i_vsync) nx = P_REQ;
            end
            P_REQ: nx = P_WAIT;
            P_WAIT: if (rd_ena) begin
                nx = P_XFER;
                m_cnt = 1;
                pop = 1;
            end
            P_XFER: begin
                if (rd_ena) begin
                    pop = (m_cnt < BURST);
                    m_cnt++;
                end else begin
                    nx = P_IDLE;
                    if (m_cnt != BURST) m_err = 1;
                    m_cnt = 0;
                end
            end
        endcase
        if (p_i_vsync) begin
            if (m_ph == P_IDLE || m_ph == P_REQ) clr = 1;
            else m_flush = 1;
        end
        if (clr) begin
            m_q.delete();
            m_ovf = 0;
            m_flush = 0;
        end else begin
            if (pop && sz > 0) void'(m_q.pop_front());
            if (pix_valid) begin
                if (sz < DEPTH) m_q.push_back(pix_data);
                else m_ovf = 1;
            end
        end
        m_ph = nx;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            chk("wr", wr, m_ph == P_REQ);
            chk("busy", busy, m_ph != P_IDLE);
            chk("level", level, m_q.size());
            chk("ovf", ovf, m_ovf);
            chk("burst_err", burst_err, m_err);
            if (m_q.size() != 0) chk("data", data, m_q[0]);
        end
    end

    task automatic push_words(input int n, input int base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1;
            pix_data  = rnd ? DATA_W'($urandom) : DATA_W'(base + i);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic burst(input int n, input bit check_seq, input int base);
        @(posedge clk); #1;
        rd_ena = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (check_seq) chk("burst_seq", data, DATA_W'(base + i));
            @(posedge clk); #1;
        end
        rd_ena = 1'b0;
    endtask

    task automatic wait_wr(input string nm);
        int t = 0;
        @(negedge clk);
        while (wr !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(nm, wr, 1);
    endtask

    initial begin
        int nwr;
        int ctl_wait;
        int ctl_left;
        int r;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_wr", wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_burst_err", burst_err, 0);

        // First burst: 256 words 0..255
        sd_ready = 1'b1;
        rd_pend  = 1'b0;
        push_words(256, 0, 0);
        @(negedge clk);
        chk("full_burst_level", level, 256);
        chk("wr_not_yet", wr, 0);
        @(negedge clk);
        chk("wr_pulse", wr, 1);
        chk("busy_req", busy, 1);
        chk("level_req", level, 256);
        burst(256, 1, 0);
        @(negedge clk);
        @(negedge clk);
        chk("after_burst_level", level, 0);
        chk("after_burst_busy", busy, 0);
        chk("after_burst_err", burst_err, 0);

        // Overflow then vsync in IDLE
        sd_ready = 1'b0;
        push_words(600, 0, 1);
        @(negedge clk);
        chk("sat_level", level, 512);
        chk("ovf_set", ovf, 1);
        @(posedge clk); #1 p_i_vsync = 1'b1;
        @(posedge clk); #1 p_i_vsync = 0;
        @(negedge clk);
        chk("vsync_level", level, 0);
        chk("vsync_ovf", ovf, 0);

        // Read priority blocks the request, then a short burst
        rd_pend  = 1'b1;
        sd_ready = 1'b1;
        push_words(300, 5000, 0);
        nwr = 0;
        repeat (10) begin
            @(negedge clk);
            nwr += int'(wr);
        end
        chk("no_wr_rd_pend", nwr, 0);
        @(posedge clk); #1 rd_pend = 1'b0;
        @(negedge clk);
        chk("wr_after_pend_0", wr, 0);
        @(negedge clk);
        chk("wr_after_pend_1", wr, 1);
        burst(255, 1, 5000);
        @(negedge clk);
        @(negedge clk);
        chk("short_burst_err", burst_err, 1);
        chk("short_level", level, 45);
        chk("short_busy", busy, 0);

        // Reset clears the sticky error; vsync mid-transfer
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst2_burst_err", burst_err, 0);
        chk("rst2_level", level, 0);
        push_words(256, 1000, 0);
        wait_wr("wr_vsync_test");
        fork
            burst(256, 1, 1000);
            begin
                for (int i = 0; i < 100; i++) begin
                    @(posedge clk); #1;
                    pix_valid = 1'b1;
                    pix_data  = DATA_W'(2000 + i);
                    p_i_vsync = (i == 50);
                end
                @(posedge clk); #1;
                pix_valid = 1'b0;
                p_i_vsync = 1'b0;
            end
        join
        @(negedge clk);
        @(negedge clk);
        chk("flush_idle_level", level, 100);
        chk("flush_idle_busy", busy, 0);
        @(negedge clk);
        chk("flush_done_level", level, 0);
        chk("flush_err", burst_err, 0);

        // Randomized traffic with a reacting controller
        ctl_wait = -1;
        ctl_left = 0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_data  = DATA_W'($urandom);
            sd_ready  = ($urandom_range(0, 7) != 0);
            rd_pend   = ($urandom_range(0, 5) == 0);
            p_i_vsync = ($urandom_range(0, 299) == 0);
            if (ctl_left > 0) begin
                rd_ena = 1'b1;
                ctl_left--;
            end else begin
                rd_ena = 1'b0;
                if (ctl_wait > 0) begin
                    ctl_wait--;
                end else if (ctl_wait == 0) begin
                    r = $urandom_range(0, 9);
                    ctl_left = (r == 0) ? BURST - 3 : (r == 1) ? BURST + 2 : BURST;
                    ctl_wait = -1;
                    rd_ena = 1'b1;
                    ctl_left--;
                end
            end
            if (wr) ctl_wait = $urandom_range(0, 3);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        p_i_vsync = 1'b0;
        rd_ena    = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
